// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave
//   AXI4-Lite slave serving DEPTH word-addressed registers of DATA_SIZE bits.
//   Write and read channels are independent, each with one transaction
//   outstanding. Accesses at or beyond DEPTH*4 bytes get an error response.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   aw*               write address channel (awsize ignored)
//   w*                write data channel (wlast ignored, single beat)
//   b*                write response channel (bresp: 0 OKAY, 1 error)
//   ar*               read address channel (arsize ignored)
//   r*                read data channel (rlast mirrors rvalid, rresp: 0 OKAY, 1 error)
module axi_lite_reg_slave #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int ID_SIZE   = 32,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [ADDR_SIZE-1:0] awaddr,
  input  logic [ID_SIZE-1:0]   awid,
  input  logic                 awsize,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 wlast,
  output logic                 bvalid,
  input  logic                 bready,
  output logic                 bresp,
  output logic [ID_SIZE-1:0]   bid,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [ADDR_SIZE-1:0] araddr,
  input  logic [ID_SIZE-1:0]   arid,
  input  logic                 arsize,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rlast,
  output logic [ID_SIZE-1:0]   rid,
  output logic                 rresp
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_SIZE-1:0] ADDR_LIMIT = ADDR_SIZE'(DEPTH * 4);

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  // Single-beat protocol: size and last carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{awsize, arsize, wlast};

  // Write side state
  w_state_t             w_state_q, w_state_d;
  logic                 aw_held_q, aw_held_d;
  logic                 aw_ok_q, aw_ok_d;
  logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
  logic [ID_SIZE-1:0]   aw_id_q, aw_id_d;
  logic                 w_held_q, w_held_d;
  logic [DATA_SIZE-1:0] w_data_q, w_data_d;
  logic                 bvalid_q, bvalid_d;
  logic                 bresp_q, bresp_d;
  logic [ID_SIZE-1:0]   bid_q, bid_d;

  // Read side state
  r_state_t             r_state_q, r_state_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rresp_q, rresp_d;
  logic [ID_SIZE-1:0]   rid_q, rid_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;

  // Register file
  logic [DATA_SIZE-1:0] regs_q [DEPTH];
  logic [DATA_SIZE-1:0] regs_d [DEPTH];

  // Readies depend only on state, never on the matching valid.
  assign awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign arready = (r_state_q == R_IDLE);

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign bid    = bid_q;
  assign rvalid = rvalid_q;
  assign rlast  = rvalid_q;
  assign rresp  = rresp_q;
  assign rid    = rid_q;
  assign rdata  = rdata_q;

  // Write channel: collect AW and W in any order, then commit once both held.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    aw_ok_d   = aw_ok_q;
    aw_idx_d  = aw_idx_q;
    aw_id_d   = aw_id_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    regs_d    = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_held_q && w_held_q) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = !aw_ok_q;
          bid_d     = aw_id_q;
          if (aw_ok_q) begin
            regs_d[aw_idx_q] = w_data_q;
          end
        end else begin
          if (awvalid && awready) begin
            aw_held_d = 1'b1;
            aw_ok_d   = (awaddr < ADDR_LIMIT);
            aw_idx_d  = awaddr[IDX_W+1:2];
            aw_id_d   = awid;
          end
          if (wvalid && wready) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: sample the array on the AR handshake. A write committing at
  // the same edge is not visible yet, so the read returns the old contents.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rid_d     = arid;
          if (araddr < ADDR_LIMIT) begin
            rdata_d = regs_q[araddr[IDX_W+1:2]];
            rresp_d = 1'b0;
          end else begin
            rdata_d = '0;
            rresp_d = 1'b1;
          end
        end
      end
      R_DATA: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      aw_ok_q   <= 1'b0;
      aw_idx_q  <= '0;
      aw_id_q   <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 1'b0;
      bid_q     <= '0;
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      aw_ok_q   <= aw_ok_d;
      aw_idx_q  <= aw_idx_d;
      aw_id_q   <= aw_id_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

  // The whole array clears on reset, so each word is an ordinary flop bank.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_regs
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        regs_q[gi] <= '0;
      end else begin
        regs_q[gi] <= regs_d[gi];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
module tb_axi_lite_reg_slave;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid = 0, awready, awsize = 0;
  logic [31:0] awaddr = 0, awid = 0;
  logic        wvalid = 0, wready, wlast = 1;
  logic [31:0] wdata = 0;
  logic        bvalid, bready = 1, bresp;
  logic [31:0] bid;
  logic        arvalid = 0, arready, arsize = 0;
  logic [31:0] araddr = 0, arid = 0;
  logic        rvalid, rready = 1, rlast, rresp;
  logic [31:0] rdata, rid;

  axi_lite_reg_slave #(.DATA_SIZE(32), .ADDR_SIZE(32), .ID_SIZE(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rid(rid), .rresp(rresp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] id; logic resp; } b_exp_t;
  typedef struct { logic [31:0] data; logic [31:0] id; logic resp; } r_exp_t;

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] model [DEPTH];
  int          checks = 0;
  int          passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Monitor: each completed response handshake is checked against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (bvalid && bready) begin
        if (b_q.size() == 0) begin
          checks++;
          $display("FAIL b_unexpected: got bid %0h with no write pending", bid);
        end else begin
          b_exp_t be;
          be = b_q.pop_front();
          chk("bid", bid, be.id);
          chk("bresp", bresp, be.resp);
          $display("B  bid=%0h bresp=%0d", bid, bresp);
        end
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) begin
          checks++;
          $display("FAIL r_unexpected: got rid %0h with no read pending", rid);
        end else begin
          r_exp_t re;
          re = r_q.pop_front();
          chk("rdata", rdata, re.data);
          chk("rid", rid, re.id);
          chk("rresp", rresp, re.resp);
          chk("rlast", rlast, 1);
          $display("R  rid=%0h rdata=%08h rresp=%0d", rid, rdata, rresp);
        end
      end
    end
  end

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] id, input int lead);
    b_exp_t e;
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int t = 0, lat = 0;
    e.id = id;
    e.resp = !in_rng(addr);
    b_q.push_back(e);
    if (in_rng(addr)) model[idx_of(addr)] = data;
    awaddr = addr; awid = id; wdata = data;
    while (!(aw_done && w_done) && t < 50) begin
      awvalid = !aw_done && (lead <= 0 || t >= lead);
      wvalid  = !w_done && (lead >= 0 || t >= -lead);
      @(negedge clk);
      if (lead > 1 && t == 1) begin
        chk("w_first_wready", wready, 0);
        chk("w_first_awready", awready, 1);
      end
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_f) aw_done = 1;
      if (w_f) w_done = 1;
      t++;
    end
    awvalid = 0; wvalid = 0;
    chk("aw_w_accept", {aw_done, w_done}, 2'b11);
    do begin @(negedge clk); lat++; end while (!bvalid && lat < 20);
    chk("b_arrives", bvalid, 1);
    chk("b_latency", lat, 2);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] id);
    r_exp_t e;
    bit done = 0, f;
    int t = 0, lat = 0;
    e.data = in_rng(addr) ? model[idx_of(addr)] : 32'h0;
    e.id = id;
    e.resp = !in_rng(addr);
    r_q.push_back(e);
    araddr = addr; arid = id; arvalid = 1;
    while (!done && t < 50) begin
      @(negedge clk);
      f = arready;
      @(posedge clk); #1;
      if (f) done = 1;
      t++;
    end
    arvalid = 0;
    chk("ar_accept", done, 1);
    do begin @(negedge clk); lat++; end while (!rvalid && lat < 20);
    chk("r_arrives", rvalid, 1);
    chk("r_latency", lat, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_readies", {awready, wready, arready}, 3'b111);
    reset = 0;
    @(posedge clk); #1;
    chk("post_rst_readies", {awready, wready, arready}, 3'b111);

    // Basic write then read
    do_write(32'h08, 32'hDEADBEEF, 5, 0);
    do_read(32'h08, 7);

    // W three cycles ahead of AW
    do_write(32'h04, 32'h12345678, 3, 3);
    do_read(32'h04, 4);

    // Out-of-range write leaves every register untouched
    for (int i = 0; i < DEPTH; i++) do_write(i * 4, $urandom, i, 0);
    do_write(32'h40, 32'hFFFFFFFF, 1, 0);
    for (int i = 0; i < DEPTH; i++) do_read(i * 4, 32'h100 + i);
    do_read(32'h40, 2);

    // Backpressure on both response channels at once
    bready = 0; rready = 0;
    do_write(32'h14, 32'hCAFEF00D, 21, 0);
    do_read(32'h14, 22);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_bvalid", bvalid, 1);
      chk("bp_bid", bid, 21);
      chk("bp_bresp", bresp, 0);
      chk("bp_rvalid", rvalid, 1);
      chk("bp_rdata", rdata, 32'hCAFEF00D);
      chk("bp_rid", rid, 22);
      chk("bp_readies", {awready, wready, arready}, 3'b000);
    end
    @(posedge clk); #1;
    bready = 1; rready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_released", {bvalid, rvalid, awready, arready}, 4'b0011);
    @(posedge clk); #1;

    // Read accepted on the same edge a write commits to the same register
    do_write(32'h0C, 32'h1, 11, 0);
    begin
      r_exp_t re;
      b_exp_t be;
      re.data = 32'h1; re.id = 12; re.resp = 0;
      r_q.push_back(re);
      be.id = 13; be.resp = 0;
      b_q.push_back(be);
      model[3] = 32'h2;
      awaddr = 32'h0C; awid = 13; wdata = 32'h2; awvalid = 1; wvalid = 1;
      @(negedge clk);
      chk("col_aw_w_ready", {awready, wready}, 2'b11);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      araddr = 32'h0C; arid = 12; arvalid = 1;
      @(negedge clk);
      chk("col_arready", arready, 1);
      @(posedge clk); #1;
      arvalid = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("col_drain", b_q.size() + r_q.size(), 0);
    end
    do_read(32'h0C, 14);

    // Randomized traffic against the array model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int lead;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = $urandom_range(0, DEPTH * 4 + 15);
      lead = int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, $urandom, lead);
      else do_read(a, $urandom);
    end

    // Reset while both responses are pending
    bready = 0; rready = 0;
    do_write(32'h18, 32'hA5A50001, 9, 0);
    do_read(32'h18, 10);
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rlast", rlast, 0);
    chk("mid_rst_readies", {awready, wready, arready}, 3'b111);
    b_q.delete();
    r_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    bready = 1; rready = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("after_rst_readies", {awready, wready, arready}, 3'b111);
    for (int i = 0; i < DEPTH; i++) do_read(i * 4, 32'h200 + i);

    repeat (3) @(posedge clk);
    #1;
    chk("final_drain", b_q.size() + r_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
